uart_frame_decoder: RTL and testbench

- Sits directly downstream of the UART receive path and consumes its byte stream (rx_data / rx_data_valid / rx_data_ready).
- Parses framed packets of the form SOF, LEN, LEN payload bytes, CSUM.
- Buffers each payload internally and emits it as a tlast-terminated stream only after the checksum verifies.
- Corrupt frames are dropped and reported on status pulses.

---
 rtl/uart_frame_decoder.sv | 184 ++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// Framed-packet decoder (SOF, LEN, payload, CSUM) that emits verified payloads as a tlast-terminated stream.
// Define INTERBYTE_TIMEOUT_EN to abort frames whose inter-byte gap reaches TIMEOUT_CYCLES.
module uart_frame_decoder #(
  parameter int unsigned WORD_LENGTH    = 8,
  parameter int unsigned MAX_LEN        = 32,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [WORD_LENGTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [WORD_LENGTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   frame_ok,
  output logic                   frame_err,
  output logic [1:0]             err_code
);

  localparam int unsigned W     = WORD_LENGTH;
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CSUM    = 3'd3;
  localparam logic [2:0] ST_EMIT    = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [W-1:0]     len, len_nxt;
  logic [W-1:0]     sum, sum_nxt;
  logic [IDX_W-1:0] wr_idx, wr_idx_nxt;
  logic [IDX_W-1:0] rd_idx, rd_idx_nxt, rd_idx_inc;
  logic [W-1:0]     tdata_nxt;
  logic             tvalid_nxt, tlast_nxt, tready_nxt;
  logic             ok_nxt, err_nxt;
  logic [1:0]       code_nxt;
  logic             in_hs, out_hs;
  logic [W-1:0]     payload_mem [MAX_LEN];

`ifdef INTERBYTE_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
`else
  // TIMEOUT_CYCLES only matters when the gap counter is built
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  assign in_hs      = s_axis_tvalid & s_axis_tready;
  assign out_hs     = m_axis_tvalid & m_axis_tready;
  assign rd_idx_inc = rd_idx + IDX_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    len_nxt    = len;
    sum_nxt    = sum;
    wr_idx_nxt = wr_idx;
    rd_idx_nxt = rd_idx;
    tdata_nxt  = m_axis_tdata;
    tvalid_nxt = m_axis_tvalid;
    tlast_nxt  = m_axis_tlast;
    ok_nxt     = 1'b0;
    err_nxt    = 1'b0;
    code_nxt   = err_code;
    case (state)
      ST_HUNT: begin
        if (in_hs && s_axis_tdata == W'(SOF_BYTE)) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (in_hs) begin
          len_nxt    = s_axis_tdata;
          sum_nxt    = s_axis_tdata;
          wr_idx_nxt = '0;
          if (s_axis_tdata == '0 || s_axis_tdata > W'(MAX_LEN)) begin
            err_nxt   = 1'b1;
            code_nxt  = 2'd1;
            state_nxt = ST_HUNT;
          end else begin
            state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (in_hs) begin
          sum_nxt = sum + s_axis_tdata;
          if (W'(wr_idx) == len - W'(1)) state_nxt = ST_CSUM;
          else                           wr_idx_nxt = wr_idx + IDX_W'(1);
        end
      end
      ST_CSUM: begin
        if (in_hs) begin
          if (W'(sum + s_axis_tdata) == '0) begin
            ok_nxt     = 1'b1;
            rd_idx_nxt = '0;
            tdata_nxt  = payload_mem[0];
            tvalid_nxt = 1'b1;
            tlast_nxt  = (len == W'(1));
            state_nxt  = ST_EMIT;
          end else begin
            err_nxt   = 1'b1;
            code_nxt  = 2'd2;
            state_nxt = ST_HUNT;
          end
        end
      end
      ST_EMIT: begin
        if (out_hs) begin
          if (m_axis_tlast) begin
            tvalid_nxt = 1'b0;
            tlast_nxt  = 1'b0;
            state_nxt  = ST_HUNT;
          end else begin
            rd_idx_nxt = rd_idx_inc;
            tdata_nxt  = payload_mem[rd_idx_inc];
            tlast_nxt  = (W'(rd_idx_inc) == len - W'(1));
          end
        end
      end
      default: state_nxt = ST_HUNT;
    endcase
`ifdef INTERBYTE_TIMEOUT_EN
    // Gap counter only runs while a frame is being received
    gap_nxt = '0;
    if ((state == ST_LEN || state == ST_PAYLOAD || state == ST_CSUM) && !in_hs) begin
      if (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1)) begin
        err_nxt   = 1'b1;
        code_nxt  = 2'd3;
        state_nxt = ST_HUNT;
      end else begin
        gap_nxt = gap_cnt + GAP_W'(1);
      end
    end
`endif
    tready_nxt = (state_nxt != ST_EMIT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= ST_HUNT;
      len           <= '0;
      sum           <= '0;
      wr_idx        <= '0;
      rd_idx        <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
      err_code      <= 2'd0;
`ifdef INTERBYTE_TIMEOUT_EN
      gap_cnt       <= '0;
`endif
    end else begin
      state         <= state_nxt;
      len           <= len_nxt;
      sum           <= sum_nxt;
      wr_idx        <= wr_idx_nxt;
      rd_idx        <= rd_idx_nxt;
      s_axis_tready <= tready_nxt;
      m_axis_tdata  <= tdata_nxt;
      m_axis_tvalid <= tvalid_nxt;
      m_axis_tlast  <= tlast_nxt;
      frame_ok      <= ok_nxt;
      frame_err     <= err_nxt;
      err_code      <= code_nxt;
`ifdef INTERBYTE_TIMEOUT_EN
      gap_cnt       <= gap_nxt;
`endif
    end
  end

  // Payload buffer, readable only after the checksum passes
  always_ff @(posedge clk) begin
    if (state == ST_PAYLOAD && in_hs) payload_mem[wr_idx] <= s_axis_tdata;
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder: directed frames plus randomized frames against a queue-based model.
module tb_uart_frame_decoder;

  localparam logic [7:0] SOF = 8'hA5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       m_axis_tlast;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  uart_frame_decoder #(
    .WORD_LENGTH(8), .MAX_LEN(32), .SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: bytes still to send, per-byte outcome tag (0 none, 1 good frame, 2 bad LEN, 3 bad CSUM), expected beats
  logic [7:0] stream_q[$];
  int         tag_q[$];
  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  int         pend = 0;
  logic [1:0] exp_code = 2'd0;
  logic       held_valid = 1'b0;
  logic [7:0] held_data = 8'h00;
  logic       held_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input int tag);
    stream_q.push_back(b);
    tag_q.push_back(tag);
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic last);
    exp_q.push_back(b);
    exp_last_q.push_back(last);
  endtask

  task automatic push_frame(input int n, input bit bad);
    logic [7:0] s, b, c;
    push_byte(SOF, 0);
    push_byte(8'(n), 0);
    s = 8'(n);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      push_byte(b, 0);
      s = s + b;
      if (!bad) expect_byte(b, i == n - 1);
    end
    c = 8'h00 - s;
    if (bad) c = c + 8'($urandom_range(1, 255));
    push_byte(c, bad ? 3 : 1);
  endtask

  task automatic push_garbage(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == SOF) b = 8'h00;
      push_byte(b, 0);
    end
  endtask

  task automatic check_cycle();
    chk("tready_vs_tvalid", s_axis_tready, !m_axis_tvalid);
    chk("frame_ok", frame_ok, pend == 1);
    chk("frame_err", frame_err, pend >= 2);
    if (pend >= 2) exp_code = (pend == 2) ? 2'd1 : 2'd2;
    chk("err_code", err_code, exp_code);
    if (pend == 1) chk("first_beat_latency", m_axis_tvalid, 1);
    if (held_valid) begin
      chk("hold_valid", m_axis_tvalid, 1);
      chk("hold_data", m_axis_tdata, held_data);
      chk("hold_last", m_axis_tlast, held_last);
    end
  endtask

  task automatic drive(input int in_mode, input int out_mode, input bit in_hs);
    if (stream_q.size() == 0) s_axis_tvalid = 1'b0;
    else if (!(s_axis_tvalid && !in_hs)) s_axis_tvalid = (in_mode == 0) || ($urandom_range(0, 2) != 0);
    s_axis_tdata = (s_axis_tvalid) ? stream_q[0] : 8'($urandom);
    case (out_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run(input int in_mode, input int out_mode, input int budget, input int stop_beats);
    int cyc = 0;
    int beats = 0;
    bit in_hs, out_hs;
    while ((stream_q.size() != 0 || exp_q.size() != 0 || pend != 0 || m_axis_tvalid) &&
           cyc < budget && (stop_beats < 0 || beats < stop_beats)) begin
      @(negedge clk);
      cyc++;
      check_cycle();
      in_hs  = s_axis_tvalid && s_axis_tready;
      out_hs = m_axis_tvalid && m_axis_tready;
      pend   = 0;
      if (out_hs) begin
        beats++;
        if (exp_q.size() == 0) chk("unexpected_beat", m_axis_tvalid, 0);
        else begin
          chk("tdata", m_axis_tdata, exp_q.pop_front());
          chk("tlast", m_axis_tlast, exp_last_q.pop_front());
        end
      end
      if (in_hs) begin
        void'(stream_q.pop_front());
        pend = tag_q.pop_front();
      end
      held_valid = m_axis_tvalid && !m_axis_tready;
      held_data  = m_axis_tdata;
      held_last  = m_axis_tlast;
      @(posedge clk);
      #1;
      drive(in_mode, out_mode, in_hs);
    end
    if (cyc >= budget) begin
      checks++;
      errors++;
      $error("FAIL run_budget: observed %0d cycles with %0d bytes and %0d beats left, required completion",
             cyc, stream_q.size(), exp_q.size());
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_code", err_code, 0);
    stream_q.delete(); tag_q.delete(); exp_q.delete(); exp_last_q.delete();
    pend = 0; exp_code = 2'd0; held_valid = 1'b0;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_s_tready", s_axis_tready, 1);
    chk("post_rst_m_tvalid", m_axis_tvalid, 0);
  endtask

  initial begin
    int seen;
    do_reset();

    // Good frame, full-rate
    push_byte(SOF, 0); push_byte(8'h03, 0);
    push_byte(8'h11, 0); push_byte(8'h22, 0); push_byte(8'h33, 0); push_byte(8'h97, 1);
    expect_byte(8'h11, 0); expect_byte(8'h22, 0); expect_byte(8'h33, 1);
    run(0, 0, 200, -1);

    // Bad checksum, then a good frame
    push_byte(SOF, 0); push_byte(8'h03, 0);
    push_byte(8'h11, 0); push_byte(8'h22, 0); push_byte(8'h33, 0); push_byte(8'h98, 3);
    push_byte(SOF, 0); push_byte(8'h03, 0);
    push_byte(8'h11, 0); push_byte(8'h22, 0); push_byte(8'h33, 0); push_byte(8'h97, 1);
    expect_byte(8'h11, 0); expect_byte(8'h22, 0); expect_byte(8'h33, 1);
    run(0, 0, 200, -1);

    // Length 0 and MAX_LEN+1, then a good MAX_LEN frame
    push_byte(SOF, 0); push_byte(8'h00, 2);
    push_byte(SOF, 0); push_byte(8'h21, 2);
    push_frame(32, 0);
    run(0, 0, 300, -1);

    // Leading garbage and SOF value inside the payload
    push_byte(8'h00, 0); push_byte(8'hFF, 0); push_byte(8'h5A, 0);
    push_byte(SOF, 0); push_byte(8'h02, 0); push_byte(SOF, 0); push_byte(8'h01, 0); push_byte(8'h58, 1);
    expect_byte(SOF, 0); expect_byte(8'h01, 1);
    run(0, 0, 200, -1);

    // Downstream backpressure toggling every cycle
    push_frame(4, 0);
    run(0, 1, 300, -1);

    // Reset in the middle of EMIT
    push_frame(4, 0);
    run(0, 0, 300, 1);
    chk("mid_emit_tvalid_before_rst", m_axis_tvalid, 1);
    do_reset();
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_ok", frame_ok, 0);
      chk("post_rst_no_err", frame_err, 0);
      chk("post_rst_idle_tvalid", m_axis_tvalid, 0);
    end

    // Inter-byte gap of 60 cycles after a partial frame
    push_byte(SOF, 0); push_byte(8'h02, 0); push_byte(8'h11, 0);
    run(0, 0, 100, -1);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (frame_err) seen++;
`ifndef INTERBYTE_TIMEOUT_EN
      chk("gap_no_err", frame_err, 0);
      chk("gap_waiting_tready", s_axis_tready, 1);
`endif
    end
`ifdef INTERBYTE_TIMEOUT_EN
    chk("timeout_pulses", seen, 1);
    chk("timeout_code", err_code, 3);
    exp_code = 2'd3;
    push_byte(8'h22, 0); push_byte(8'hCB, 0);
`else
    chk("gap_err_code_held", err_code, exp_code);
    push_byte(8'h22, 0); push_byte(8'hCB, 1);
    expect_byte(8'h11, 0); expect_byte(8'h22, 1);
`endif
    run(0, 0, 200, -1);

    // Randomized frames with random valid gaps and downstream stalls
    for (int f = 0; f < 24; f++) begin
      int kind, n;
      kind = int'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0:       n = 1;
        1:       n = 32;
        default: n = int'($urandom_range(1, 32));
      endcase
      if (kind <= 5) push_frame(n, 0);
      else if (kind <= 7) push_frame(n, 1);
      else if (kind == 8) begin
        push_byte(SOF, 0);
        push_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255)), 2);
      end else begin
        push_garbage(int'($urandom_range(1, 4)));
        push_frame(n, 0);
      end
    end
    run(2, 2, 20000, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
